// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic Y86-64 F/D/E/M/W pipeline latch with stall/bubble
// control, a sticky stall+bubble conflict flag and optional performance counters.
// Optional feature macro: PIPE_REG_PERF_EN (stall/bubble counters; tied to 0 when undefined).
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 256,
  parameter int unsigned       STAT_W      = 3,
  parameter logic [STAT_W-1:0] STAT_BUB    = '0,
  parameter logic [3:0]        NOP_ICODE   = 4'h1,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_stall,
  input  logic              i_bubble,
  input  logic [3:0]        i_icode,
  input  logic [STAT_W-1:0] i_stat,
  input  logic [DATA_W-1:0] i_data,
  output logic [3:0]        o_icode,
  output logic [STAT_W-1:0] o_stat,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_conflict,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  // Stall has priority; a bubble only takes effect when not stalled.
  logic doBubble;
  assign doBubble = i_bubble & ~i_stall;

  logic [3:0]        icodeNext;
  logic [STAT_W-1:0] statNext;
  logic [DATA_W-1:0] dataNext;
  logic              validNext;

  // Next-state selection: hold by default, then bubble or normal load.
  always_comb begin
    icodeNext = o_icode;
    statNext  = o_stat;
    dataNext  = o_data;
    validNext = o_valid;
    if (doBubble) begin
      icodeNext = NOP_ICODE;
      statNext  = STAT_BUB;
      dataNext  = BUBBLE_DATA;
      validNext = 1'b0;
    end else if (!i_stall) begin
      icodeNext = i_icode;
      statNext  = i_stat;
      dataNext  = i_data;
      validNext = 1'b1;
    end
  end

  // Stage contents; reset loads the same NOP content as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_icode <= NOP_ICODE;
      o_stat  <= STAT_BUB;
      o_data  <= BUBBLE_DATA;
      o_valid <= 1'b0;
    end else begin
      o_icode <= icodeNext;
      o_stat  <= statNext;
      o_data  <= dataNext;
      o_valid <= validNext;
    end
  end

  // Sticky flag for simultaneous stall and bubble requests; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_conflict <= 1'b0;
    end else if (i_stall && i_bubble) begin
      o_conflict <= 1'b1;
    end
  end

`ifdef PIPE_REG_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating stall/bubble counters; perf_clr wins over incrementing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stall_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else if (perf_clr) begin
      o_stall_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else begin
      if (i_stall && (o_stall_cnt != CNT_MAX)) begin
        o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      end
      if (doBubble && (o_bubble_cnt != CNT_MAX)) begin
        o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
      end
    end
  end
`else
  // Counters absent in this build: outputs read zero and perf_clr is ignored.
  logic unusedPerfClr;
  assign unusedPerfClr = perf_clr;
  assign o_stall_cnt   = '0;
  assign o_bubble_cnt  = '0;
`endif

endmodule
